// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve timing, paddle hit/miss at edge columns, speed-up, scoring, win detect.
// All outputs registered (one clk after the tick decision); no backpressure, evaluated on tick strobes.
module pong_game_ctrl #(
  parameter int SERVE_TICKS      = 1000,
  parameter int POINT_TICKS      = 500,
  parameter int WIN_SCORE        = 9,
  parameter int PADDLE_H         = 3,
  parameter int SPEED_INIT       = 4,
  parameter int SPEED_MAX        = 15,
  parameter int HITS_PER_SPEEDUP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic [3:0]        ball_x,
  input  logic [3:0]        ball_y,
  input  logic [3:0]        lpad_y,
  input  logic [3:0]        rpad_y,
  output logic              ball_hold,
  output logic signed [4:0] ball_speed,
  output logic              bounce_x,
  output logic [3:0]        score_l,
  output logic [3:0]        score_r,
  output logic [2:0]        state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] POINT = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  localparam int TW = 16;
  localparam logic [TW-1:0] SERVE_LD = TW'(SERVE_TICKS);
  localparam logic [TW-1:0] POINT_LD = TW'(POINT_TICKS);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);
  localparam logic [5:0]    PAD_H    = 6'(PADDLE_H);
  localparam logic [4:0]    SPD_INIT = 5'(SPEED_INIT);
  localparam logic [4:0]    SPD_MAX  = 5'(SPEED_MAX);
  localparam logic [7:0]    HITS_N   = 8'(HITS_PER_SPEEDUP);

  logic          start_q, serve_dir;
  logic [TW-1:0] timer;
  logic [7:0]    hits;

  logic [2:0]    state_n;
  logic [TW-1:0] timer_n;
  logic [7:0]    hits_n, hits_inc;
  logic          dir_n, bounce_n, hold_n;
  logic [4:0]    speed_n, spd_mag, mag_hit;
  logic [3:0]    score_l_n, score_r_n;
  logic          start_rise, timer_exp, speedup;
  logic          left_edge, right_edge, lhit, rhit;

  always_comb begin
    start_rise = start & ~start_q;
    timer_exp  = (timer <= TW'(1));
    spd_mag    = ball_speed[4] ? (~ball_speed + 5'd1) : ball_speed;
    hits_inc   = hits + 8'd1;
    speedup    = (hits_inc >= HITS_N);
    mag_hit    = (speedup && (spd_mag < SPD_MAX)) ? spd_mag + 5'd1 : spd_mag;
    // 6-bit compare so a paddle near the bottom row cannot wrap around
    lhit       = ({2'b0, ball_y} >= {2'b0, lpad_y}) && ({2'b0, ball_y} < ({2'b0, lpad_y} + PAD_H));
    rhit       = ({2'b0, ball_y} >= {2'b0, rpad_y}) && ({2'b0, ball_y} < ({2'b0, rpad_y} + PAD_H));
    left_edge  = tick && (ball_x == 4'd0) && ball_speed[4];
    right_edge = tick && (ball_x == 4'hF) && !ball_speed[4] && (ball_speed != 5'sd0);

    state_n   = state;
    timer_n   = timer;
    hits_n    = hits;
    dir_n     = serve_dir;
    speed_n   = ball_speed;
    bounce_n  = 1'b0;
    score_l_n = score_l;
    score_r_n = score_r;

    case (state)
      IDLE, OVER: begin
        speed_n = 5'd0;
        if (start_rise) begin
          state_n   = SERVE;
          score_l_n = 4'd0;
          score_r_n = 4'd0;
          dir_n     = 1'b1;
          timer_n   = SERVE_LD;
        end
      end
      SERVE: begin
        speed_n = 5'd0;
        if (tick) begin
          if (timer_exp) begin
            state_n = PLAY;
            hits_n  = 8'd0;
            speed_n = serve_dir ? SPD_INIT : (~SPD_INIT + 5'd1);
          end else begin
            timer_n = timer - TW'(1);
          end
        end
      end
      PLAY: begin
        if (left_edge) begin
          if (lhit) begin
            speed_n  = mag_hit;
            bounce_n = 1'b1;
            hits_n   = speedup ? 8'd0 : hits_inc;
          end else begin
            score_r_n = (score_r == 4'hF) ? score_r : score_r + 4'd1;
            dir_n     = 1'b0;
            speed_n   = 5'd0;
            timer_n   = POINT_LD;
            state_n   = POINT;
          end
        end else if (right_edge) begin
          if (rhit) begin
            speed_n  = ~mag_hit + 5'd1;
            bounce_n = 1'b1;
            hits_n   = speedup ? 8'd0 : hits_inc;
          end else begin
            score_l_n = (score_l == 4'hF) ? score_l : score_l + 4'd1;
            dir_n     = 1'b1;
            speed_n   = 5'd0;
            timer_n   = POINT_LD;
            state_n   = POINT;
          end
        end
      end
      POINT: begin
        speed_n = 5'd0;
        if (tick) begin
          if (timer_exp) begin
            if ((score_l == WIN) || (score_r == WIN)) begin
              state_n = OVER;
            end else begin
              state_n = SERVE;
              timer_n = SERVE_LD;
            end
          end else begin
            timer_n = timer - TW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        speed_n = 5'd0;
      end
    endcase

    hold_n = (state_n == IDLE) || (state_n == SERVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ball_hold  <= 1'b1;
      ball_speed <= 5'sd0;
      bounce_x   <= 1'b0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      start_q    <= 1'b0;
      serve_dir  <= 1'b1;
      timer      <= '0;
      hits       <= 8'd0;
    end else begin
      state      <= state_n;
      ball_hold  <= hold_n;
      ball_speed <= $signed(speed_n);
      bounce_x   <= bounce_n;
      score_l    <= score_l_n;
      score_r    <= score_r_n;
      start_q    <= start;
      serve_dir  <= dir_n;
      timer      <= timer_n;
      hits       <= hits_n;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game scenarios then randomized play against a rule-level model.
module tb_pong_game_ctrl;
  localparam int ST = 3, PT = 5, WS = 3, PH = 3, SI = 4, SM = 6, HP = 4;

  logic              clk;
  logic              reset, tick, start;
  logic [3:0]        ball_x, ball_y, lpad_y, rpad_y;
  logic              ball_hold, bounce_x;
  logic signed [4:0] ball_speed;
  logic [3:0]        score_l, score_r;
  logic [2:0]        state;

  int n_vec = 0;
  int n_bad = 0;

  // rule-level model of the game
  int m_state, m_timer, m_hits, m_speed, m_sl, m_sr;
  bit m_dir, m_sq, m_bounce;

  pong_game_ctrl #(
    .SERVE_TICKS(ST), .POINT_TICKS(PT), .WIN_SCORE(WS), .PADDLE_H(PH),
    .SPEED_INIT(SI), .SPEED_MAX(SM), .HITS_PER_SPEEDUP(HP)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .lpad_y(lpad_y), .rpad_y(rpad_y),
    .ball_hold(ball_hold), .ball_speed(ball_speed), .bounce_x(bounce_x),
    .score_l(score_l), .score_r(score_r), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_timer = 0; m_hits = 0; m_speed = 0;
    m_sl = 0; m_sr = 0; m_dir = 1; m_sq = 0; m_bounce = 0;
  endtask

  task automatic paddle_event(input int pad, input bit left);
    int mag;
    if (ball_y >= pad && ball_y <= pad + PH - 1) begin
      m_hits++;
      mag = (m_speed < 0) ? -m_speed : m_speed;
      if (m_hits == HP) begin
        mag = (mag + 1 > SM) ? SM : mag + 1;
        m_hits = 0;
      end
      m_speed = left ? mag : -mag;
      m_bounce = 1;
    end else begin
      if (left) m_sr = (m_sr == 15) ? 15 : m_sr + 1;
      else      m_sl = (m_sl == 15) ? 15 : m_sl + 1;
      m_dir = !left;
      m_speed = 0;
      m_timer = PT;
      m_state = 3;
    end
  endtask

  task automatic model_clock();
    bit rise;
    rise = start && !m_sq;
    m_sq = start;
    m_bounce = 0;
    case (m_state)
      0, 4: if (rise) begin
        m_state = 1; m_sl = 0; m_sr = 0; m_dir = 1; m_timer = ST;
      end
      1: if (tick) begin
        if (m_timer <= 1) begin
          m_state = 2; m_hits = 0; m_speed = m_dir ? SI : -SI;
        end else m_timer--;
      end
      2: if (tick) begin
        if (ball_x == 0 && m_speed < 0)       paddle_event(int'(lpad_y), 1'b1);
        else if (ball_x == 15 && m_speed > 0) paddle_event(int'(rpad_y), 1'b0);
      end
      3: if (tick) begin
        if (m_timer <= 1) begin
          if (m_sl == WS || m_sr == WS) m_state = 4;
          else begin m_state = 1; m_timer = ST; end
        end else m_timer--;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check_val("state",   int'(state),      m_state);
    check_val("hold",    int'(ball_hold),  (m_state <= 1) ? 1 : 0);
    check_val("speed",   int'(ball_speed), m_speed);
    check_val("bounce",  int'(bounce_x),   int'(m_bounce));
    check_val("score_l", int'(score_l),    m_sl);
    check_val("score_r", int'(score_r),    m_sr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_clock();
    compare_all();
  endtask

  // assert reset in the middle of a cycle; outputs must clear without a clock edge
  task automatic do_async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // one paddle hit on whichever edge the ball is heading to, then one idle clk
  task automatic hit_once(input int off);
    tick = 1'b1;
    ball_y = 4'd7;
    if (m_speed > 0) begin ball_x = 4'hF; rpad_y = 4'(7 - off); end
    else             begin ball_x = 4'h0; lpad_y = 4'(7 - off); end
    step();
    check_val("hit_bounce", int'(bounce_x), 1);
    tick = 1'b0;
    ball_x = 4'd7;
    step();
    check_val("bounce_drop", int'(bounce_x), 0);
  endtask

  initial begin
    int r, pad;
    reset = 1'b1; tick = 1'b0; start = 1'b0;
    ball_x = 4'd7; ball_y = 4'd7; lpad_y = 4'd0; rpad_y = 4'd0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
    step();

    // start from IDLE, serve after ST ticks
    start = 1'b1; step();
    check_val("t2_serve", int'(state), 1);
    tick = 1'b1; step(); step();
    check_val("t2_still_serve", int'(state), 1);
    step();
    check_val("t2_play", int'(state), 2);
    check_val("t2_speed", int'(ball_speed), SI);
    check_val("t2_hold", int'(ball_hold), 0);

    // hits: speed-up every HP hits, saturating at SM; pad edges exercised via offsets
    for (int k = 0; k < 4; k++) hit_once(k % 3);
    check_val("t4_speedup", int'(ball_speed), SI + 1);
    for (int k = 0; k < 8; k++) hit_once((k + 1) % 3);
    check_val("t4_saturate", int'(ball_speed), SM);
    hit_once(2);
    check_val("t1_pre_speed", int'(ball_speed), -SM);
    do_async_reset();
    check_val("t1_state", int'(state), 0);
    check_val("t1_speed", int'(ball_speed), 0);

    // right miss, point freeze, re-serve toward the right
    start = 1'b0; step();
    start = 1'b1; tick = 1'b1; ball_x = 4'd7; step();
    repeat (3) step();
    check_val("t5_play_speed", int'(ball_speed), SI);
    ball_x = 4'd0; step();
    check_val("t5_away_no_action", int'(ball_speed), SI);
    ball_x = 4'hF; ball_y = 4'd0; rpad_y = 4'd10; step();
    check_val("t5_score_l", int'(score_l), 1);
    check_val("t5_point", int'(state), 3);
    check_val("t5_speed0", int'(ball_speed), 0);
    repeat (PT - 1) step();
    check_val("t5_still_point", int'(state), 3);
    step();
    check_val("t5_serve", int'(state), 1);
    ball_x = 4'd7; repeat (ST) step();
    check_val("t5_reserve_speed", int'(ball_speed), SI);

    // one right hit, then left misses until the right player wins
    ball_x = 4'hF; ball_y = 4'd7; rpad_y = 4'd7; step();
    check_val("t6_neg", int'(ball_speed), -SI);
    for (int i = 0; i < WS; i++) begin
      ball_x = 4'd0; lpad_y = 4'd5; ball_y = (i == 0) ? 4'd8 : 4'd4;
      step();
      check_val("t6_score_r", int'(score_r), i + 1);
      ball_x = 4'd7;
      repeat (PT) step();
      if (i < WS - 1) begin
        check_val("t6_serve", int'(state), 1);
        repeat (ST) step();
        check_val("t6_serve_left", int'(ball_speed), -SI);
      end
    end
    check_val("t6_over", int'(state), 4);
    check_val("t6_over_hold", int'(ball_hold), 0);

    // restart from OVER with a coincident tick that must not be counted
    start = 1'b0; tick = 1'b0; step();
    start = 1'b1; tick = 1'b1; step();
    check_val("t6_restart", int'(state), 1);
    check_val("t6_scores_clr", int'(score_r), 0);
    repeat (ST - 1) step();
    check_val("t6_tick_ignored", int'(state), 1);
    step();
    check_val("t6_play", int'(state), 2);

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) start = ~start;
      r = int'($urandom_range(0, 3));
      ball_x = (r == 0) ? 4'd0 : (r == 1) ? 4'hF : 4'($urandom_range(0, 15));
      ball_y = 4'($urandom_range(0, 15));
      pad = int'(ball_y) - int'($urandom_range(0, 3));
      if (pad < 0) pad = 0;
      lpad_y = ($urandom_range(0, 3) != 0) ? 4'(pad) : 4'($urandom_range(0, 15));
      rpad_y = ($urandom_range(0, 3) != 0) ? 4'(pad) : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_async_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
